uart_frame_rx: RTL and testbench

//  Sits directly downstream of uart_rx and consumes its byte/new_value/clear handshake.

---
 rtl/uart_frame_rx_pkg.sv | 20 ++
 rtl/uart_frame_rx_if.sv | 10 +
 rtl/uart_frame_buf.sv | 28 ++
 rtl/uart_frame_rx.sv | 153 +++++++++++++++
 tb/tb_uart_frame_rx.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the framed UART receiver: FSM encodings, defaults,
// and the inter-byte timeout limit helper.
package uart_frame_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN    = 3'd1;
  localparam logic [2:0] ST_PAY    = 3'd2;
  localparam logic [2:0] ST_CHK    = 3'd3;
  localparam logic [2:0] ST_STREAM = 3'd4;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  // One UART byte time is 10 bit periods (start + 8 data + stop).
  function automatic int tmo_limit(input int bytes, input int clk_hz, input int baud);
    longint t;
    t = longint'(bytes) * 64'd10 * longint'(clk_hz) / longint'(baud);
    return int'(t);
  endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Payload byte stream from the frame receiver to the network loader (valid/ready).
interface uart_frame_rx_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port and one
// combinational read port.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Parses SYNC, LEN, PAYLOAD[LEN], CHK frames from uart_rx, checks the XOR sum,
// buffers the payload and streams good payloads out over valid/ready.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int         MAX_LEN       = 16,
  parameter logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE,
  parameter int         CLK_HZ        = 12000000,
  parameter int         BAUD          = 9600,
  parameter int         TIMEOUT_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_new_value,
  input  logic                   rx_error,
  output logic                   rx_clear,
  uart_frame_rx_if.master        stream,
  output logic                   frame_ok,
  output logic                   frame_err,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);

  localparam int         LW      = $clog2(MAX_LEN + 1);
  localparam int         AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         T       = tmo_limit(TIMEOUT_BYTES, CLK_HZ, BAUD);
  localparam int         TW      = $clog2(T + 1);
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

  logic [2:0]    state;
  logic [LW-1:0] len;
  logic [LW-1:0] wr_idx;
  logic [LW-1:0] rd_idx;
  logic [7:0]    chk;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    rdata;

  logic take, in_frame, tmo_exp, len_ok, last_wr, last_rd, hs, we;

  // uart_rx holds new_value until it sees the clear, so the clear cycle is blind.
  assign take     = rx_new_value && !rx_clear;
  assign in_frame = (state == ST_LEN) || (state == ST_PAY) || (state == ST_CHK);
  assign tmo_exp  = in_frame && !take && (tmo_cnt == TW'(T - 1));
  assign len_ok   = (rx_data != 8'h00) && (rx_data <= MAX_LEN8);
  assign last_wr  = (wr_idx == len - LW'(1));
  assign last_rd  = (rd_idx == len - LW'(1));
  assign we       = take && !rx_error && (state == ST_PAY);

  assign busy             = (state != ST_IDLE);
  assign stream.out_valid = (state == ST_STREAM);
  assign stream.out_data  = stream.out_valid ? rdata : 8'h00;
  assign stream.out_last  = stream.out_valid && last_rd;
  assign hs               = stream.out_valid && stream.out_ready;

  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (wr_idx[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_idx[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (take || !in_frame) begin
      tmo_cnt <= '0;
    end else if (!tmo_exp) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      chk       <= 8'h00;
      rx_clear  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      drop_cnt  <= 8'h00;
    end else begin
      rx_clear  <= take;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take && !rx_error && rx_data == SYNC_BYTE) state <= ST_LEN;
        end
        ST_LEN: begin
          if (take) begin
            if (rx_error || !len_ok) begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              len    <= rx_data[LW-1:0];
              chk    <= rx_data;
              wr_idx <= '0;
              state  <= ST_PAY;
            end
          end else if (tmo_exp) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_PAY: begin
          if (take) begin
            if (rx_error) begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              chk    <= chk ^ rx_data;
              wr_idx <= wr_idx + LW'(1);
              if (last_wr) state <= ST_CHK;
            end
          end else if (tmo_exp) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_CHK: begin
          if (take) begin
            if (!rx_error && rx_data == chk) begin
              frame_ok <= 1'b1;
              rd_idx   <= '0;
              state    <= ST_STREAM;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end else if (tmo_exp) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_STREAM: begin
          if (take && !rx_error && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          if (hs) begin
            if (last_rd) state <= ST_IDLE;
            else         rd_idx <= rd_idx + LW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: drives the uart_rx byte handshake and
// checks framing, streaming, backpressure, drops, timeout and async reset.
module tb_uart_frame_rx;

  localparam int T = 50000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_new_value;
  logic       rx_error;
  logic       rx_clear;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;
  logic [7:0] drop_cnt;

  uart_frame_rx_if sif ();

  uart_frame_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_new_value (rx_new_value),
    .rx_error     (rx_error),
    .rx_clear     (rx_clear),
    .stream       (sif),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int ok_cnt  = 0;
  int err_cnt = 0;
  int clr_cnt = 0;
  int vld_cnt = 0;
  logic [7:0] oq [$];
  logic       lq [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_ok)      ok_cnt  <= ok_cnt + 1;
      if (frame_err)     err_cnt <= err_cnt + 1;
      if (rx_clear)      clr_cnt <= clr_cnt + 1;
      if (sif.out_valid) vld_cnt <= vld_cnt + 1;
      if (sif.out_valid && sif.out_ready) begin
        oq.push_back(sif.out_data);
        lq.push_back(sif.out_last);
      end
    end
  end

  int ok0, err0, clr0, vld0, q0;
  logic [7:0] fq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    ok0  = ok_cnt;
    err0 = err_cnt;
    clr0 = clr_cnt;
    vld0 = vld_cnt;
    q0   = oq.size();
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    rx_data      = b;
    rx_error     = e;
    rx_new_value = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (rx_clear) begin
        got = 1'b1;
        break;
      end
    end
    rx_new_value = 1'b0;
    rx_error     = 1'b0;
    chk("rx_clear_seen", 32'(got), 32'd1);
  endtask

  task automatic send_q();
    for (int i = 0; i < fq.size(); i++) send(fq[i], 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 100);
    @(posedge clk); #1;
    chk("idle", 32'(busy), 32'd0);
  endtask

  task automatic qbyte(input string tag, input int idx, input logic [7:0] d, input logic l);
    if (idx < oq.size()) begin
      chk(tag, 32'(oq[idx]), 32'(d));
      chk(tag, 32'(lq[idx]), 32'(l));
    end else begin
      chk(tag, 32'hDEAD, 32'(d));
    end
  endtask

  initial begin
    int cyc;
    rst_n         = 1'b0;
    rx_data       = 8'h00;
    rx_new_value  = 1'b0;
    rx_error      = 1'b0;
    sif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_clear", 32'(rx_clear), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ok_err", {30'd0, frame_ok, frame_err}, 32'd0);
    rst_n = 1'b1;

    // good frame, also checks CHK-byte latency
    sif.out_ready = 1'b1;
    mark();
    fq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    send_q();
    send(8'h03, 1'b0);
    chk("lat_ok", 32'(frame_ok), 32'd1);
    chk("lat_valid", 32'(sif.out_valid), 32'd1);
    wait_idle();
    chk("t1_ok", 32'(ok_cnt - ok0), 32'd1);
    chk("t1_err", 32'(err_cnt - err0), 32'd0);
    chk("t1_n", 32'(oq.size() - q0), 32'd3);
    qbyte("t1_b0", q0, 8'h11, 1'b0);
    qbyte("t1_b1", q0 + 1, 8'h22, 1'b0);
    qbyte("t1_b2", q0 + 2, 8'h33, 1'b1);
    chk("t1_drop", 32'(drop_cnt), 32'd0);

    // bad checksum
    mark();
    fq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    send_q();
    wait_idle();
    chk("t2_err", 32'(err_cnt - err0), 32'd1);
    chk("t2_ok", 32'(ok_cnt - ok0), 32'd0);
    chk("t2_vld", 32'(vld_cnt - vld0), 32'd0);

    // bad lengths, then garbage before a good one-byte frame
    mark();
    fq = '{8'hA5, 8'h00};
    send_q();
    wait_idle();
    chk("t3_len0", 32'(err_cnt - err0), 32'd1);
    fq = '{8'hA5, 8'h11};
    send_q();
    wait_idle();
    chk("t3_len17", 32'(err_cnt - err0), 32'd2);
    mark();
    fq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_q();
    wait_idle();
    chk("t3_err", 32'(err_cnt - err0), 32'd0);
    chk("t3_ok", 32'(ok_cnt - ok0), 32'd1);
    qbyte("t3_b0", q0, 8'h7E, 1'b1);

    // backpressure and drops; XOR of 02 AA 55 is FD
    sif.out_ready = 1'b0;
    mark();
    fq = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFD};
    send_q();
    @(posedge clk); #1;
    chk("t4_ok", 32'(ok_cnt - ok0), 32'd1);
    clr0 = clr_cnt;
    for (int i = 0; i < 3; i++) begin
      send(8'h40 + 8'(i), 1'b0);
      chk("t4_hold_dat", 32'(sif.out_data), 32'hAA);
      chk("t4_hold_vld", 32'(sif.out_valid), 32'd1);
    end
    chk("t4_drop", 32'(drop_cnt), 32'd3);
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    sif.out_ready = 1'b0;
    chk("t4_next_dat", 32'(sif.out_data), 32'h55);
    chk("t4_next_last", 32'(sif.out_last), 32'd1);
    @(posedge clk); #1;
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    sif.out_ready = 1'b0;
    chk("t4_drop_valid", 32'(sif.out_valid), 32'd0);
    wait_idle();
    chk("t4_n", 32'(oq.size() - q0), 32'd2);
    qbyte("t4_b0", q0, 8'hAA, 1'b0);
    qbyte("t4_b1", q0 + 1, 8'h55, 1'b1);
    chk("t4_clr", 32'(clr_cnt - clr0), 32'd3);

    // timeout after a partial payload
    sif.out_ready = 1'b1;
    mark();
    fq = '{8'hA5, 8'h02, 8'h11};
    send_q();
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!frame_err && cyc < 60000);
    chk("t5_tmo_fired", 32'(frame_err), 32'd1);
    chk("t5_tmo_window", 32'(cyc >= T - 2 && cyc <= T + 2), 32'd1);
    wait_idle();

    // rx_error on the first payload byte
    mark();
    fq = '{8'hA5, 8'h02};
    send_q();
    send(8'h33, 1'b1);
    wait_idle();
    chk("t5_rxerr", 32'(err_cnt - err0), 32'd1);

    // async reset mid-payload
    fq = '{8'hA5, 8'h04, 8'h11};
    send_q();
    chk("t6_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_valid", 32'(sif.out_valid), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    chk("t6_clear", 32'(rx_clear), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mark();
    fq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_q();
    wait_idle();
    chk("t6_ok", 32'(ok_cnt - ok0), 32'd1);
    qbyte("t6_b0", q0, 8'h7E, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
